dmi_req_buffer: RTL



---
 rtl/dmi_req_buffer.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dmi_req_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : dmi_req_buffer
//  Purpose  : Decoupling buffer between the JTAG DTM and the debug-module CSR
//             block. Requests are queued in a FIFO and issued only when a
//             response slot is reserved. A DTM hard-reset flush clears both
//             queues and silently drains responses still in flight.
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// First-word fall-through FIFO. A push on a full FIFO is ignored even when a
// pop happens in the same cycle; a pop on an empty FIFO is ignored, so there
// is no bypass path from data_i to data_o.
// ----------------------------------------------------------------------------
module dmi_req_buffer_fifo #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [Width-1:0]         data_i,
  output logic [Width-1:0]         data_o,
  output logic                     full_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [Width-1:0] mem [0:Depth-1];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  count;
  logic             empty;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full_o  = (count == CntW'(Depth));
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty;
  assign data_o  = mem[rd_ptr];
  assign count_o = count;

  // Pointer and occupancy bookkeeping; a clear empties the FIFO at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count <= count + 1'b1;
      end else if (!push_ok && pop_ok) begin
        count <= count - 1'b1;
      end
    end
  end

  // Storage needs no reset: data_o is only consumed while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= data_i;
    end
  end

endmodule

// ----------------------------------------------------------------------------
// Top level: request queue, credit-gated issue, response queue and the
// flush/discard machinery.
// ----------------------------------------------------------------------------
module dmi_req_buffer #(
  parameter int unsigned ReqDepth  = 2,
  parameter int unsigned RespDepth = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  // DTM side
  input  logic [40:0]                  dtm_req_i,
  input  logic                         dtm_req_valid_i,
  output logic                         dtm_req_ready_o,
  output logic [33:0]                  dtm_resp_o,
  output logic                         dtm_resp_valid_o,
  input  logic                         dtm_resp_ready_i,
  // DM side
  output logic [40:0]                  dm_req_o,
  output logic                         dm_req_valid_o,
  input  logic                         dm_req_ready_i,
  input  logic [33:0]                  dm_resp_i,
  input  logic                         dm_resp_valid_i,
  // Status
  output logic [$clog2(RespDepth):0]   outstanding_o,
  output logic                         flushing_o
);

  localparam int unsigned OutW = $clog2(RespDepth) + 1;

  // Request path
  logic [40:0]                 req_head;
  logic                        req_full;
  logic [$clog2(ReqDepth):0]   req_count;
  logic                        req_empty;
  logic                        req_push;
  logic                        issue;
  logic                        credit_ok;

  // Response path
  logic [33:0]                 resp_head;
  logic                        resp_full;
  logic [OutW-1:0]             resp_count;
  logic                        resp_push;
  logic                        resp_pop;

  // Outstanding / discard tracking
  logic [OutW-1:0]             outstanding;
  logic [OutW-1:0]             discard_cnt;
  logic                        discarding;
  logic                        resp_dec;

  // --------------------------------------------------------------------------
  // Request side
  // --------------------------------------------------------------------------
  assign req_empty = (req_count == '0);

  // Ready comes from the registered occupancy only, so a pop in the same
  // cycle never frees room for a push on a full FIFO.
  assign dtm_req_ready_o = !req_full && !flush_i;
  assign req_push        = dtm_req_valid_i && dtm_req_ready_o;

  // Every request in flight or already answered-but-unread holds a response
  // slot; issue only when at least one slot remains free.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, resp_count}) < (OutW + 1)'(RespDepth);

  assign dm_req_valid_o = !req_empty && credit_ok && !flush_i;
  assign dm_req_o       = dm_req_valid_o ? req_head : '0;
  assign issue          = dm_req_valid_o && dm_req_ready_i;

  dmi_req_buffer_fifo #(
    .Width (41),
    .Depth (ReqDepth)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (flush_i),
    .push_i  (req_push),
    .pop_i   (issue),
    .data_i  (dtm_req_i),
    .data_o  (req_head),
    .full_o  (req_full),
    .count_o (req_count)
  );

  // --------------------------------------------------------------------------
  // Response side
  // --------------------------------------------------------------------------
  assign discarding = (discard_cnt != '0);
  assign flushing_o = discarding;

  // Responses belonging to flushed requests (arriving in the flush cycle or
  // while discard_cnt is non-zero) are dropped instead of queued.
  assign resp_push = dm_resp_valid_i && !flush_i && !discarding;

  assign dtm_resp_valid_o = (resp_count != '0);
  assign dtm_resp_o       = dtm_resp_valid_o ? resp_head : '0;
  assign resp_pop         = dtm_resp_valid_o && dtm_resp_ready_i;

  dmi_req_buffer_fifo #(
    .Width (34),
    .Depth (RespDepth)
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (flush_i),
    .push_i  (resp_push),
    .pop_i   (resp_pop),
    .data_i  (dm_resp_i),
    .data_o  (resp_head),
    .full_o  (resp_full),
    .count_o (resp_count)
  );

  // --------------------------------------------------------------------------
  // Outstanding request counter
  // --------------------------------------------------------------------------
  // Guard against underflow so a stray response cannot wrap the counter.
  assign resp_dec      = dm_resp_valid_i && (outstanding != '0);
  assign outstanding_o = outstanding;

  // Track requests issued to the DM and not yet answered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding <= '0;
    end else if (issue && !resp_dec) begin
      outstanding <= outstanding + 1'b1;
    end else if (!issue && resp_dec) begin
      outstanding <= outstanding - 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Discard counter
  // --------------------------------------------------------------------------
  // On flush, every request still in flight will be answered but must not be
  // forwarded; a response landing in the flush cycle itself is already gone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      discard_cnt <= '0;
    end else if (flush_i) begin
      discard_cnt <= resp_dec ? outstanding - 1'b1 : outstanding;
    end else if (discarding && dm_resp_valid_i) begin
      discard_cnt <= discard_cnt - 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Protocol checks
  // --------------------------------------------------------------------------
  a_resp_without_request : assert property (
    @(posedge clk_i) disable iff (!rst_ni) dm_resp_valid_i |-> (outstanding != '0)
  );

  a_resp_fifo_overflow : assert property (
    @(posedge clk_i) disable iff (!rst_ni) resp_push |-> !resp_full
  );

endmodule

`default_nettype wire
